triumph_if_stage: RTL and testbench
===================================

Name: triumph_if_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. It owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered with their PC in a small FIFO and presented to decode as instr_valid/instr_data/instr_pc. Branch/jump redirects from execute flush the FIFO, discard any in-flight response and restart fetch at the target.

Parameters:
BOOT_ADDR, 32'h0000_0000, fetch PC after reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
imem_req_o  out  1  fetch request
imem_addr_o  out  32  word address of request (bits[1:0]=0)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  32  response instruction word
branch_valid_i  in  1  redirect from execute
branch_target_i  in  32  redirect target
id_ready_i  in  1  decode accepts instruction this cycle
instr_valid_o  out  1  instruction available to decode
instr_data_o  out  32  instruction word
instr_pc_o  out  32  PC of instr_data_o

Behaviour:
- Reset values: fetch_pc=BOOT_ADDR, FIFO empty, state=S_IDLE, imem_req_o=0 while rst_i high, instr_valid_o=0, instr_data_o=0, instr_pc_o=0.
- At most one outstanding request. States: S_IDLE (none outstanding), S_WAIT (outstanding, keep data), S_FLUSH (outstanding, discard data).
- credit = fifo_count + (state!=S_IDLE) - pop, where pop = instr_valid_o & id_ready_i.
- issue_ok = credit < FIFO_DEPTH and (S_IDLE, or S_WAIT with imem_rvalid_i).
- imem_req_o = issue_ok & ~branch_valid_i (combinational); imem_addr_o = fetch_pc.
- req & gnt: fetch_pc <= fetch_pc+4 (wraps 0xFFFF_FFFC->0); state -> S_WAIT; PC of the request is latched as req_pc.
- S_WAIT & rvalid: push {req_pc, rdata} into FIFO; -> S_IDLE, or stay S_WAIT if re-granted in the same cycle.
- S_FLUSH & rvalid: data dropped, no push; -> S_IDLE. No requests are issued in S_FLUSH.
- Redirect (branch_valid_i): fetch_pc <= {branch_target_i[31:2],2'b00}; FIFO cleared; S_WAIT -> S_FLUSH; S_IDLE stays S_IDLE; S_FLUSH stays S_FLUSH. A redirect in the same cycle as rvalid in S_WAIT drops that data -> S_IDLE. Redirect beats push and pop.
- instr_valid_o = ~fifo_empty & ~branch_valid_i; data/pc come from the FIFO head (registered, no bypass).
- Latency: gnt in cycle n, rvalid in n+1, instr_valid_o in n+2. Sustained throughput is 1 instr/cycle when gnt and rvalid are immediate and id_ready_i=1.
- Push and pop in the same cycle are always legal. Full FIFO is impossible with a pending push, because credit blocks the issue.
- id_ready_i=0: FIFO holds its head, outputs stable; once credit is exhausted, imem_req_o drops.
- imem_gnt_i without imem_req_o is ignored. imem_rvalid_i in S_IDLE is ignored (protocol error, assertion in bench).
- Reset mid-operation: immediate return to reset values; a late rvalid after reset is ignored (S_IDLE).

Decomposition:
- Add to triumph_riscv_defines.v: IF_BOOT_ADDR, IF state encodings (IF_S_IDLE=2'd0, IF_S_WAIT=2'd1, IF_S_FLUSH=2'd2), INSTR_NOP (32'h0000_0013).
- Sub-module triumph_fetch_fifo: synchronous FIFO, 64-bit entries {pc,instr}, parameter DEPTH, ports push/pop/flush/empty/count, asynchronous reset.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle later with rdata=0x00000013 → imem_addr_o 0x0,0x4,0x8…; instr_valid_o high from cycle 2 onward, pc 0x0,0x4 in order, one per cycle.
- id_ready_i=0 for 5 cycles during streaming → exactly 2 instructions buffered, imem_req_o low, head pc stable. Release → pcs continue without gap or duplicate.
- branch_valid_i with target 0x100 while a request for 0x8 is outstanding → rvalid for 0x8 dropped. Next request is addr 0x100, and the first delivered pc is 0x100.
- branch_target_i=0x203 → imem_addr_o=0x200, instr_pc_o=0x200.
- gnt delayed 3 cycles with req held → addr stable 0x0 throughout; fetch_pc advances only on the gnt cycle.
- rst_i pulsed while in S_WAIT, rvalid arriving after reset → no instr_valid_o from the stale data; fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/triumph_if_stage_pkg.sv
// Shared types and constants for the triumph fetch stage: boot address,
// fetch state encodings, NOP word and the {pc, instr} buffer entry.
package triumph_if_stage_pkg;

  localparam logic [31:0] IF_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_S_IDLE  = 2'd0,
    IF_S_WAIT  = 2'd1,
    IF_S_FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/triumph_if_stage_fifo.sv
// Fetch buffer: small synchronous FIFO of {pc, instr} entries with a
// single-cycle flush. The head entry is read straight from the storage flops.
module triumph_fetch_fifo
  import triumph_if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t wdata_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t rdata_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/triumph_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request
// outstanding and buffers returned words for decode; redirects flush it all.
module triumph_if_stage
  import triumph_if_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = IF_BOOT_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        id_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_data_o,
  output logic [31:0] instr_pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic          fifo_push, fifo_flush, fifo_empty, pop;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, fifo_wdata;
  logic [CW:0]   credit;
  logic          outstanding, can_issue, issue_ok, fire;

  // Credit counts buffer slots already spoken for, including the word in flight.
  assign outstanding = (state_q != IF_S_IDLE);
  assign pop         = instr_valid_o & id_ready_i;
  assign credit      = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};
  assign can_issue   = (state_q == IF_S_IDLE) | ((state_q == IF_S_WAIT) & imem_rvalid_i);
  assign issue_ok    = (credit < (CW+1)'(FIFO_DEPTH)) & can_issue;
  assign imem_req_o  = issue_ok & ~branch_valid_i & ~rst_i;
  assign imem_addr_o = fetch_pc_q;
  assign fire        = imem_req_o & imem_gnt_i;

  assign fifo_wdata  = '{pc: req_pc_q, instr: imem_rdata_i};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (branch_valid_i) begin
      fetch_pc_d = word_align(branch_target_i);
      fifo_flush = 1'b1;
      case (state_q)
        IF_S_WAIT:  state_d = imem_rvalid_i ? IF_S_IDLE : IF_S_FLUSH;
        IF_S_FLUSH: state_d = imem_rvalid_i ? IF_S_IDLE : IF_S_FLUSH;
        default:    state_d = IF_S_IDLE;
      endcase
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
      end
      case (state_q)
        IF_S_IDLE: begin
          if (fire) state_d = IF_S_WAIT;
        end
        IF_S_WAIT: begin
          if (imem_rvalid_i) begin
            fifo_push = 1'b1;
            state_d   = fire ? IF_S_WAIT : IF_S_IDLE;
          end
        end
        IF_S_FLUSH: begin
          if (imem_rvalid_i) state_d = IF_S_IDLE;
        end
        default: state_d = IF_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IF_S_IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  triumph_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid_o = ~fifo_empty & ~branch_valid_i;
  assign instr_data_o  = fifo_head.instr;
  assign instr_pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_triumph_if_stage.sv
// Directed bench for triumph_if_stage: a per-cycle vector table for streaming,
// stall, redirects, plus hand sequences for delayed grant and mid-flight reset.
module tb_triumph_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_valid_i;
  logic [31:0] branch_target_i;
  logic        id_ready_i;
  logic        instr_valid_o;
  logic [31:0] instr_data_o;
  logic [31:0] instr_pc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  triumph_if_stage #(
    .BOOT_ADDR  (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .branch_valid_i  (branch_valid_i),
    .branch_target_i (branch_target_i),
    .id_ready_i      (id_ready_i),
    .instr_valid_o   (instr_valid_o),
    .instr_data_o    (instr_data_o),
    .instr_pc_o      (instr_pc_o)
  );

  typedef struct packed {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic [31:0] pc;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic logic [31:0] dw(input logic [31:0] pc);
    return 32'hC0DE_0000 + pc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic br, input logic [31:0] tgt, input logic rdy);
    imem_gnt_i      = gnt;
    imem_rvalid_i   = rv;
    imem_rdata_i    = rdata;
    branch_valid_i  = br;
    branch_target_i = tgt;
    id_ready_i      = rdy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req_o},    32'd0);
    check({tag, "_addr"},  imem_addr_o,            32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, "_data"},  instr_data_o,           32'd0);
    check({tag, "_pc"},    instr_pc_o,             32'd0);
  endtask

  initial begin
    //          gnt  rv   rdata          br   tgt          rdy   req  addr         valid data          pc
    vecs[0]  = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h000,    1'b0, 32'd0,        32'd0};
    vecs[1]  = '{1'b1,1'b1,dw(32'h000),   1'b0,32'd0,      1'b1, 1'b1,32'h004,    1'b0, 32'd0,        32'd0};
    vecs[2]  = '{1'b1,1'b1,dw(32'h004),   1'b0,32'd0,      1'b1, 1'b1,32'h008,    1'b1, dw(32'h000),  32'h000};
    vecs[3]  = '{1'b1,1'b1,dw(32'h008),   1'b0,32'd0,      1'b1, 1'b1,32'h00C,    1'b1, dw(32'h004),  32'h004};
    vecs[4]  = '{1'b1,1'b1,dw(32'h00C),   1'b0,32'd0,      1'b0, 1'b0,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[5]  = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b0, 1'b0,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[6]  = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b0, 1'b0,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[7]  = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b0, 1'b0,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[8]  = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b0, 1'b0,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[9]  = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h010,    1'b1, dw(32'h008),  32'h008};
    vecs[10] = '{1'b1,1'b1,dw(32'h010),   1'b0,32'd0,      1'b1, 1'b1,32'h014,    1'b1, dw(32'h00C),  32'h00C};
    vecs[11] = '{1'b1,1'b0,32'd0,         1'b1,32'h100,    1'b1, 1'b0,32'h018,    1'b0, 32'd0,        32'd0};
    vecs[12] = '{1'b0,1'b1,32'hDEAD_BEEF, 1'b0,32'd0,      1'b1, 1'b0,32'h100,    1'b0, 32'd0,        32'd0};
    vecs[13] = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h100,    1'b0, 32'd0,        32'd0};
    vecs[14] = '{1'b0,1'b1,dw(32'h100),   1'b0,32'd0,      1'b1, 1'b1,32'h104,    1'b0, 32'd0,        32'd0};
    vecs[15] = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h104,    1'b1, dw(32'h100),  32'h100};
    vecs[16] = '{1'b0,1'b0,32'd0,         1'b1,32'h203,    1'b1, 1'b0,32'h104,    1'b0, 32'd0,        32'd0};
    vecs[17] = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h200,    1'b0, 32'd0,        32'd0};
    vecs[18] = '{1'b0,1'b1,dw(32'h200),   1'b0,32'd0,      1'b1, 1'b1,32'h204,    1'b0, 32'd0,        32'd0};
    vecs[19] = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h204,    1'b1, dw(32'h200),  32'h200};
    vecs[20] = '{1'b1,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h204,    1'b0, 32'd0,        32'd0};
    vecs[21] = '{1'b0,1'b1,dw(32'h204),   1'b1,32'h300,    1'b1, 1'b0,32'h208,    1'b0, 32'd0,        32'd0};
    vecs[22] = '{1'b0,1'b0,32'd0,         1'b0,32'd0,      1'b1, 1'b1,32'h300,    1'b0, 32'd0,        32'd0};

    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check_reset_outputs("reset");

    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].br, vecs[i].tgt, vecs[i].rdy);
      @(negedge clk_i);
      check($sformatf("v%0d_req", i),   {31'd0, imem_req_o},    {31'd0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  imem_addr_o,            vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].valid});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_data", i), instr_data_o, vecs[i].data);
        check($sformatf("v%0d_pc", i),   instr_pc_o,   vecs[i].pc);
      end
      @(posedge clk_i);
      #1;
    end

    // Fresh start, then grant withheld for three cycles with req held.
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check_reset_outputs("reset2");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk_i);
      check($sformatf("gdly%0d_req", i),  {31'd0, imem_req_o}, 32'd1);
      check($sformatf("gdly%0d_addr", i), imem_addr_o,         32'h0);
      @(posedge clk_i);
      #1;
    end
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("gnt_cycle_addr", imem_addr_o, 32'h0);
    @(posedge clk_i);
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("post_gnt_addr", imem_addr_o,         32'h4);
    check("post_gnt_req",  {31'd0, imem_req_o}, 32'd0);
    @(posedge clk_i);
    #1;

    // Reset while the request for 0x0 is outstanding; its response arrives late.
    rst_i = 1'b1;
    #1;
    check("midrst_req",   {31'd0, imem_req_o},    32'd0);
    check("midrst_addr",  imem_addr_o,            32'h0);
    check("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("late_rv_req",  {31'd0, imem_req_o}, 32'd1);
    check("late_rv_addr", imem_addr_o,         32'h0);
    @(posedge clk_i);
    #1;
    drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("stale_valid", {31'd0, instr_valid_o}, 32'd0);
    check("restart_req", {31'd0, imem_req_o},    32'd1);
    check("restart_addr", imem_addr_o,           32'h0);
    @(posedge clk_i);
    #1;
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("restart_valid0", {31'd0, instr_valid_o}, 32'd0);
    check("restart_addr4",  imem_addr_o,            32'h4);
    @(posedge clk_i);
    #1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);
    check("restart_valid1", {31'd0, instr_valid_o}, 32'd1);
    check("restart_pc",     instr_pc_o,             32'h0);
    check("restart_data",   instr_data_o,           32'h0000_0013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
